// File: rtl/sm_dmem_responder.sv
// sm_dmem_responder: data-memory responder for the single-cycle core.
// It serves a word RAM plus a 256-byte I/O page.
// The I/O page holds a GPIO register, a free-running cycle counter and a byte
// transmit FIFO that drains through a valid/ready port.
// Reads are combinational. All state changes on the rising clock edge.
module sm_dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic [31:0] dataMemory_address,
  input  logic        dataMemory_writeEnable,
  input  logic [31:0] dataMemory_writeData,
  output logic [31:0] dataMemory_readData,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [5:0] OFF_GPIO   = 6'h00;
  localparam logic [5:0] OFF_CYCLE  = 6'h01;
  localparam logic [5:0] OFF_TXDATA = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;

  // Storage: RAM and FIFO payload are deliberately left out of reset
  logic [31:0]   ramMem_r [DEPTH_WORDS];
  logic [7:0]    fifoMem_r [FIFO_DEPTH];
  logic [31:0]   gpio_r;
  logic [31:0]   cycle_r;
  logic [PW-1:0] rdPtr_r;
  logic [PW-1:0] wrPtr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  // Decode and handshake terms
  logic          ramSel_s;
  logic [AW-1:0] ramIdx_s;
  logic          ioSel_s;
  logic [5:0]    ioOff_s;
  logic          ioWr_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          pushReq_s;
  logic          pushOk_s;
  logic          ovfSet_s;
  logic          ovfClr_s;
  logic [31:0]   status_s;
  logic [31:0]   readData_s;

  assign ramSel_s  = (dataMemory_address < 32'(DEPTH_WORDS * 4));
  assign ramIdx_s  = dataMemory_address[AW+1:2];
  assign ioSel_s   = (dataMemory_address[31:8] == IO_BASE[31:8]);
  assign ioOff_s   = dataMemory_address[7:2];
  assign ioWr_s    = dataMemory_writeEnable && ioSel_s;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == CW'(FIFO_DEPTH));
  assign pop_s     = !empty_s && tx_ready;
  assign pushReq_s = ioWr_s && (ioOff_s == OFF_TXDATA);
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign pushOk_s  = pushReq_s && (!full_s || pop_s);
  assign ovfSet_s  = pushReq_s && full_s && !pop_s;
  assign ovfClr_s  = ioWr_s && (ioOff_s == OFF_STATUS) && dataMemory_writeData[2];

  assign status_s  = {20'h0_0000, 4'(count_r), 5'b0_0000, overflow_r, full_s, empty_s};

  assign dataMemory_readData = readData_s;
  assign gpio_out            = gpio_r;
  assign tx_valid            = !empty_s;
  assign tx_data             = fifoMem_r[rdPtr_r];

  // Combinational read mux over RAM, I/O registers and unmapped space
  always_comb begin
    readData_s = 32'h0000_0000;
    if (ramSel_s) begin
      readData_s = ramMem_r[ramIdx_s];
    end else if (ioSel_s) begin
      case (ioOff_s)
        OFF_GPIO:   readData_s = gpio_r;
        OFF_CYCLE:  readData_s = cycle_r;
        OFF_STATUS: readData_s = status_s;
        default:    readData_s = 32'h0000_0000;
      endcase
    end else begin
      readData_s = 32'h0000_0000;
    end
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (dataMemory_writeEnable && ramSel_s) begin
      ramMem_r[ramIdx_s] <= dataMemory_writeData;
    end
  end

  // FIFO payload write at the write pointer
  always_ff @(posedge clk) begin
    if (pushOk_s) begin
      fifoMem_r[wrPtr_r] <= dataMemory_writeData[7:0];
    end
  end

  // GPIO register and cycle counter; a CYCLE write overrides the increment
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      gpio_r  <= 32'h0000_0000;
      cycle_r <= 32'h0000_0000;
    end else begin
      if (ioWr_s && (ioOff_s == OFF_GPIO)) begin
        gpio_r <= dataMemory_writeData;
      end
      if (ioWr_s && (ioOff_s == OFF_CYCLE)) begin
        cycle_r <= dataMemory_writeData;
      end else begin
        cycle_r <= cycle_r + 32'd1;
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow; a set beats a clear
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      rdPtr_r    <= {PW{1'b0}};
      wrPtr_r    <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PW'(1);
      end
      if (pushOk_s) begin
        wrPtr_r <= wrPtr_r + PW'(1);
      end
      case ({pushOk_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (ovfSet_s) begin
        overflow_r <= 1'b1;
      end else if (ovfClr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm_dmem_responder.sv
// Testbench for sm_dmem_responder.
// Directed steps follow the block's intended use cases, then a randomized phase
// is checked against a queue/array reference model.
module tb_sm_dmem_responder;

  localparam int DEPTH_WORDS = 64;
  localparam int FIFO_DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst_p = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        we = 1'b0;
  logic [31:0] wd = 32'h0;
  logic [31:0] rd;
  logic [31:0] gpioOut;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady = 1'b0;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] mRam [DEPTH_WORDS];
  logic [31:0] mGpio = 32'h0;
  logic [31:0] mCycle = 32'h0;
  logic [7:0]  mQ [$];
  bit          mOvf = 1'b0;

  logic [7:0]  drainExp [8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};

  always #5 clk = ~clk;

  sm_dmem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .IO_BASE(32'hFFFF_0000)
  ) dut (
    .clk(clk),
    .rst_p(rst_p),
    .dataMemory_address(addr),
    .dataMemory_writeEnable(we),
    .dataMemory_writeData(wd),
    .dataMemory_readData(rd),
    .gpio_out(gpioOut),
    .tx_data(txData),
    .tx_valid(txValid),
    .tx_ready(txReady)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mStatus();
    return {20'h0, 4'(mQ.size()), 5'h0, mOvf, (mQ.size() == FIFO_DEPTH), (mQ.size() == 0)};
  endfunction

  function automatic logic [31:0] mRead(input logic [31:0] a);
    logic [7:0] off;
    off = a[7:0] & 8'hFC;
    if (a < DEPTH_WORDS * 4) return mRam[a / 4];
    if (a[31:8] == 24'hFFFF00) begin
      case (off)
        8'h00:   return mGpio;
        8'h04:   return mCycle;
        8'h0C:   return mStatus();
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic mReset();
    mGpio  = 32'h0;
    mCycle = 32'h0;
    mQ.delete();
    mOvf   = 1'b0;
  endtask

  // Apply the current bus/handshake inputs to the model as one clock edge
  task automatic modelEdge();
    bit pop;
    bit push;
    bit clr;
    bit setOvf;
    pop = 1'b0; push = 1'b0; clr = 1'b0; setOvf = 1'b0;
    if (rst_p) begin
      mReset();
      return;
    end
    pop = (mQ.size() != 0) && txReady;
    mCycle = mCycle + 32'd1;
    if (we) begin
      if (addr < DEPTH_WORDS * 4) begin
        mRam[addr / 4] = wd;
      end else if (addr[31:8] == 24'hFFFF00) begin
        case (addr[7:2])
          6'd0:    mGpio = wd;
          6'd1:    mCycle = wd;
          6'd2:    push = 1'b1;
          6'd3:    clr = wd[2];
          default: ;
        endcase
      end
    end
    if (pop) void'(mQ.pop_front());
    if (push) begin
      if (mQ.size() < FIFO_DEPTH) mQ.push_back(wd[7:0]);
      else setOvf = 1'b1;
    end
    if (setOvf) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic setBus(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr = a;
    we = w;
    wd = d;
    #1;
  endtask

  initial begin
    logic [31:0] prior;
    logic [31:0] a;
    int idx;
    int r;

    // Reset state
    tick();
    tick();
    setBus(32'hFFFF_0004, 1'b0, 32'h0);
    chk("rst_cycle", rd, 32'h0);
    setBus(32'hFFFF_000C, 1'b0, 32'h0);
    chk("rst_status", rd, 32'h0000_0001);
    chk("rst_gpio", gpioOut, 32'h0);
    chk("rst_txvalid", {31'h0, txValid}, 32'h0);

    // Cycle counter after five edges out of reset
    rst_p = 1'b0;
    setBus(32'hFFFF_0004, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("cycle_5", rd, 32'd5);
    chk("cycle_5_model", rd, mRead(addr));

    // Fill RAM with random contents, then the directed word at 0x10
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      setBus(32'(i * 4), 1'b1, $urandom);
      tick();
    end
    prior = mRam[4];
    setBus(32'h0000_0010, 1'b1, 32'h1122_3344);
    chk("ram_old_during_write", rd, prior);
    tick();
    setBus(32'h0000_0010, 1'b0, 32'h0);
    chk("ram_rd_10", rd, 32'h1122_3344);
    setBus(32'h0000_0013, 1'b0, 32'h0);
    chk("ram_rd_13", rd, 32'h1122_3344);

    // GPIO and decode holes
    setBus(32'hFFFF_0000, 1'b1, 32'hA5A5_0001);
    tick();
    chk("gpio_out", gpioOut, 32'hA5A5_0001);
    setBus(32'hFFFF_0000, 1'b0, 32'h0);
    chk("gpio_rd", rd, 32'hA5A5_0001);
    setBus(32'h0000_8000, 1'b0, 32'h0);
    chk("unmapped_8000", rd, 32'h0);
    setBus(32'hFFFF_0010, 1'b0, 32'h0);
    chk("io_hole_10", rd, 32'h0);

    // Cycle load and wrap
    setBus(32'hFFFF_0004, 1'b1, 32'hFFFF_FFFE);
    tick();
    setBus(32'hFFFF_0004, 1'b0, 32'h0);
    chk("cycle_load", rd, 32'hFFFF_FFFE);
    tick();
    chk("cycle_max", rd, 32'hFFFF_FFFF);
    tick();
    chk("cycle_wrap", rd, 32'h0);

    // FIFO fill with the sink stalled
    txReady = 1'b0;
    for (int k = 0; k < 8; k++) begin
      setBus(32'hFFFF_0008, 1'b1, 32'(8'h41 + k));
      tick();
    end
    setBus(32'hFFFF_000C, 1'b0, 32'h0);
    chk("fifo_full_status", rd, 32'h0000_0802);
    chk("fifo_head", {24'h0, txData}, 32'h41);
    setBus(32'hFFFF_0008, 1'b0, 32'h0);
    chk("txdata_reads_zero", rd, 32'h0);
    setBus(32'hFFFF_0008, 1'b1, 32'h49);
    tick();
    setBus(32'hFFFF_000C, 1'b0, 32'h0);
    chk("fifo_ovf_status", rd, 32'h0000_0806);
    chk("fifo_head_held", {24'h0, txData}, 32'h41);
    setBus(32'hFFFF_000C, 1'b1, 32'h4);
    tick();
    setBus(32'hFFFF_000C, 1'b0, 32'h0);
    chk("ovf_cleared", rd, 32'h0000_0802);

    // Push into a full FIFO while the head pops
    txReady = 1'b1;
    setBus(32'hFFFF_0008, 1'b1, 32'h50);
    tick();
    txReady = 1'b0;
    setBus(32'hFFFF_000C, 1'b0, 32'h0);
    chk("push_pop_full_status", rd, 32'h0000_0802);
    chk("push_pop_head", {24'h0, txData}, 32'h42);

    // Drain in order
    txReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", {31'h0, txValid}, 32'h1);
      chk("drain_data", {24'h0, txData}, {24'h0, drainExp[k]});
      tick();
    end
    chk("drained_valid", {31'h0, txValid}, 32'h0);
    chk("drained_status", rd, 32'h0000_0001);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        idx = $urandom_range(0, DEPTH_WORDS - 1);
        if (idx == 4) idx = 5;
        a = 32'(idx * 4 + $urandom_range(0, 3));
      end else if (r < 8) begin
        a = 32'hFFFF_0000 + 32'($urandom_range(0, 31));
      end else begin
        a = 32'h0000_1000 + 32'($urandom_range(0, 32'h00FF_FFFF));
      end
      txReady = ($urandom_range(0, 2) == 0);
      setBus(a, ($urandom_range(0, 1) == 1), $urandom);
      chk("rnd_read", rd, mRead(a));
      chk("rnd_gpio", gpioOut, mGpio);
      chk("rnd_valid", {31'h0, txValid}, {31'h0, (mQ.size() != 0)});
      if (mQ.size() != 0) chk("rnd_txdata", {24'h0, txData}, {24'h0, mQ[0]});
      tick();
    end

    // Reset mid-drain
    txReady = 1'b1;
    setBus(32'h0, 1'b0, 32'h0);
    for (int k = 0; k < FIFO_DEPTH + 1; k++) tick();
    txReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setBus(32'hFFFF_0008, 1'b1, 32'(8'h60 + k));
      tick();
    end
    setBus(32'h0, 1'b0, 32'h0);
    chk("pre_rst_valid", {31'h0, txValid}, 32'h1);
    txReady = 1'b1;
    #1;
    rst_p = 1'b1;
    mReset();
    #1;
    chk("async_rst_valid", {31'h0, txValid}, 32'h0);
    chk("async_rst_gpio", gpioOut, 32'h0);
    tick();
    rst_p = 1'b0;
    setBus(32'hFFFF_000C, 1'b0, 32'h0);
    chk("post_rst_status", rd, 32'h0000_0001);
    chk("post_rst_gpio", gpioOut, 32'h0);
    setBus(32'h0000_0010, 1'b0, 32'h0);
    chk("post_rst_ram", rd, 32'h1122_3344);
    setBus(32'hFFFF_0004, 1'b0, 32'h0);
    tick();
    chk("post_rst_cycle1", rd, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
